// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the RV32I ALU control decoder and its pipeline.
// Codes are 5 bits wide so the optional M-extension codes fit.
package alu_ctrl_pkg;

  localparam int unsigned ALU_CODE_W = 5;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  localparam logic [ALU_CODE_W-1:0] ALU_AND    = 5'b00000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR     = 5'b00001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD    = 5'b00010;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL    = 5'b00011;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR    = 5'b00100;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL    = 5'b00101;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB    = 5'b00110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT    = 5'b00111;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU   = 5'b01000;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA    = 5'b01001;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL    = 5'b10000;
  localparam logic [ALU_CODE_W-1:0] ALU_MULH   = 5'b10001;
  localparam logic [ALU_CODE_W-1:0] ALU_MULHSU = 5'b10010;
  localparam logic [ALU_CODE_W-1:0] ALU_MULHU  = 5'b10011;
  localparam logic [ALU_CODE_W-1:0] ALU_DIV    = 5'b10100;
  localparam logic [ALU_CODE_W-1:0] ALU_DIVU   = 5'b10101;
  localparam logic [ALU_CODE_W-1:0] ALU_REM    = 5'b10110;
  localparam logic [ALU_CODE_W-1:0] ALU_REMU   = 5'b10111;

  localparam logic [6:0] FUNC7_BASE = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

  // The func7=0000000 R-type row, also used by I-type ALU ops.
  function automatic logic [ALU_CODE_W-1:0] base_row(input logic [2:0] func3);
    logic [ALU_CODE_W-1:0] code;
    code = ALU_ADD;
    case (func3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, func7, func3} -> {ALU code, illegal} decoder.
// Define RV_M_EXT_EN to decode func7=0000001 R-type ops as M-extension codes.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0]            alu_op_i,
  input  logic [6:0]            func7_i,
  input  logic [2:0]            func3_i,
  output logic [ALU_CODE_W-1:0] ctrl_o,
  output logic                  illegal_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    ctrl_o    = ALU_ADD;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALU_OP_MEM: ctrl_o = ALU_ADD;
      ALU_OP_BRANCH: begin
        case (func3_i)
          3'b000, 3'b001: ctrl_o = ALU_SUB;
          3'b100, 3'b101: ctrl_o = ALU_SLT;
          3'b110, 3'b111: ctrl_o = ALU_SLTU;
          default:        illegal_o = 1'b1;
        endcase
      end
      ALU_OP_RTYPE: begin
        if (func7_i == FUNC7_BASE) begin
          ctrl_o = base_row(func3_i);
        end else if (func7_i == FUNC7_ALT && func3_i == 3'b000) begin
          ctrl_o = ALU_SUB;
        end else if (func7_i == FUNC7_ALT && func3_i == 3'b101) begin
          ctrl_o = ALU_SRA;
`ifdef RV_M_EXT_EN
        end else if (func7_i == FUNC7_MEXT) begin
          ctrl_o = {2'b10, func3_i};
`endif
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: begin
        // I-type: func7 carries immediate bits except for the shift forms.
        if (func3_i == 3'b001) begin
          if (func7_i == FUNC7_BASE) ctrl_o = ALU_SLL;
          else                       illegal_o = 1'b1;
        end else if (func3_i == 3'b101) begin
          if (func7_i == FUNC7_BASE)     ctrl_o = ALU_SRL;
          else if (func7_i == FUNC7_ALT) ctrl_o = ALU_SRA;
          else                           illegal_o = 1'b1;
        end else begin
          ctrl_o = base_row(func3_i);
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Pipelined ALU control decoder: decode, then STAGES elastic valid/ready registers.
// RV_M_EXT_EN enables M-extension decode and requires CTRL_W >= 5.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 1,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [6:0]        func7,
  input  logic [2:0]        func3,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("alu_control_pipe: STAGES must be 1..4");
  end
`ifdef RV_M_EXT_EN
  if (CTRL_W < 5) begin : g_bad_ctrl_w
    $error("alu_control_pipe: CTRL_W must be >= 5 when RV_M_EXT_EN is defined");
  end
`endif

  logic [ALU_CODE_W-1:0] dec_code;
  logic                  dec_ill;
  logic [CTRL_W-1:0]     dec_ctrl;

  alu_ctrl_decode u_decode (
    .alu_op_i  (alu_op),
    .func7_i   (func7),
    .func3_i   (func3),
    .ctrl_o    (dec_code),
    .illegal_o (dec_ill)
  );

  assign dec_ctrl = CTRL_W'(dec_code);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] ill_s;
  logic [CTRL_W-1:0] ctrl_s [STAGES];

  // A stage can load if it, or any stage after it, is empty (bubbles collapse).
  always_comb begin
    ld             = '0;
    ld[STAGES-1]   = !vld[STAGES-1] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      ld[k] = !vld[k] || ld[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              v_in;
    logic              ill_in;
    logic [CTRL_W-1:0] c_in;
    logic              valid_q;
    logic              valid_d;
    logic              ill_q;
    logic [CTRL_W-1:0] ctrl_q;

    if (k == 0) begin : g_head
      assign v_in   = in_valid;
      assign c_in   = dec_ctrl;
      assign ill_in = dec_ill;
    end else begin : g_body
      assign v_in   = vld[k-1];
      assign c_in   = ctrl_s[k-1];
      assign ill_in = ill_s[k-1];
    end

    assign valid_d = flush ? 1'b0 : (ld[k] ? v_in : valid_q);

    // NOTE: data registers are reset too, so alu_ctrl/illegal read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        ill_q   <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
        valid_q <= valid_d;
        if (ld[k] && v_in) begin
          ctrl_q <= c_in;
          ill_q  <= ill_in;
        end
      end
    end

    assign vld[k]    = valid_q;
    assign ctrl_s[k] = ctrl_q;
    assign ill_s[k]  = ill_q;
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[STAGES-1];
  assign alu_ctrl  = ctrl_s[STAGES-1];
  assign illegal   = ill_s[STAGES-1];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && illegal && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Randomised and directed bench for alu_control_pipe against a queue-based model.
// Build with RV_M_EXT_EN defined to exercise the M-extension decode.
module tb_alu_control_pipe;

  localparam int STAGES = 3;
  localparam int CNT_W  = 4;
`ifdef RV_M_EXT_EN
  localparam int CTRL_W = 5;
  localparam bit M_EN   = 1'b1;
`else
  localparam int CTRL_W = 4;
  localparam bit M_EN   = 1'b0;
`endif
  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [6:0]        func7;
  logic [2:0]        func3;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  alu_control_pipe #(
    .STAGES (STAGES),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .func7       (func7),
    .func3       (func3),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_ctrl    (alu_ctrl),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int edge_now;
  int model_cnt;
  bit last_acc;

  typedef struct {
    int         acc;
    logic [4:0] code;
    bit         ill;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode tables.
  function automatic void ref_decode(input logic [1:0] op, input logic [6:0] f7,
                                     input logic [2:0] f3, output logic [4:0] c,
                                     output bit ill);
    logic [4:0] row [8];
    row = '{5'd2, 5'd3, 5'd7, 5'd8, 5'd4, 5'd5, 5'd1, 5'd0};
    c   = 5'd2;
    ill = 1'b0;
    case (op)
      2'd0: c = 5'd2;
      2'd1: begin
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
        else if (f3 < 3'd2)           c = 5'd6;
        else if (f3 < 3'd6)           c = 5'd7;
        else                          c = 5'd8;
      end
      2'd2: begin
        if (f7 == 7'h00)                    c = row[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) c = 5'd6;
        else if (f7 == 7'h20 && f3 == 3'd5) c = 5'd9;
        else if (M_EN && f7 == 7'h01)       c = 5'd16 + 5'(f3);
        else                                ill = 1'b1;
      end
      default: begin
        if (f3 == 3'd1) begin
          if (f7 == 7'h00) c = 5'd3;
          else             ill = 1'b1;
        end else if (f3 == 3'd5) begin
          if (f7 == 7'h00)      c = 5'd5;
          else if (f7 == 7'h20) c = 5'd9;
          else                  ill = 1'b1;
        end else begin
          c = row[f3];
        end
      end
    endcase
  endfunction

  task automatic drive(input bit v, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input bit ordy, input bit fl);
    in_valid  = v;
    alu_op    = op;
    func7     = f7;
    func3     = f3;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: starts at a falling edge with inputs already driven.
  task automatic cycle();
    bit         exp_rdy;
    bit         exp_ov;
    bit         hs_in;
    bit         hs_out;
    logic [4:0] c;
    bit         il;
    exp_t       e;
    #1;
    exp_rdy = (sb.size() < STAGES) || out_ready;
    exp_ov  = (sb.size() > 0) && (edge_now >= sb[0].acc + STAGES - 1);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      e = sb[0];
      check("alu_ctrl", 32'(alu_ctrl), 32'(e.code[CTRL_W-1:0]));
      check("illegal", 32'(illegal), 32'(e.ill));
    end
    hs_out = exp_ov && out_ready;
    hs_in  = in_valid && exp_rdy;
    ref_decode(alu_op, func7, func3, c, il);
    @(posedge clk);
    edge_now++;
    if (hs_out) begin
      if (sb[0].ill && model_cnt < CNT_MAX) model_cnt++;
      void'(sb.pop_front());
    end
    last_acc = hs_in && !flush;
    if (flush) sb.delete();
    else if (hs_in) sb.push_back('{edge_now, c, il});
    #1;
    check("illegal_cnt", 32'(illegal_cnt), 32'(model_cnt));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'd0, 7'd0, 3'd0, 1'b1, 1'b0);
    repeat (n) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [1:0] bp_op [5];
  logic [6:0] bp_f7 [5];
  logic [2:0] bp_f3 [5];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    edge_now  = 0;
    model_cnt = 0;
    last_acc  = 1'b0;
    rst       = 1'b1;
    drive(1'b0, 2'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_cnt", 32'(illegal_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Pass-through: R-type SUB.
    drive(1'b1, 2'b10, 7'b0100000, 3'b000, 1'b1, 1'b0);
    cycle();
    idle(STAGES + 1);

    // Illegal I-type shift encoding.
    drive(1'b1, 2'b11, 7'b0010000, 3'b101, 1'b1, 1'b0);
    cycle();
    idle(STAGES + 1);

    // M-extension DIV encoding (legal only when the feature is built in).
    drive(1'b1, 2'b10, 7'b0000001, 3'b100, 1'b1, 1'b0);
    cycle();
    idle(STAGES + 1);

    // Counter saturation.
    repeat (2 ** CNT_W + 3) begin
      drive(1'b1, 2'b11, 7'b0010000, 3'b101, 1'b1, 1'b0);
      cycle();
    end
    idle(STAGES + 1);
    #1;
    check("cnt_saturated", 32'(illegal_cnt), 32'(CNT_MAX));
    @(negedge clk);

    // Backpressure: five ops, out_ready low for the first six cycles.
    bp_op = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd0};
    bp_f7 = '{7'h00, 7'h20, 7'h00, 7'h55, 7'h00};
    bp_f3 = '{3'd0, 3'd5, 3'd6, 3'd3, 3'd0};
    begin
      int i;
      int cyc;
      i   = 0;
      cyc = 0;
      while (i < 5 && cyc < 40) begin
        drive(1'b1, bp_op[i], bp_f7[i], bp_f3[i], cyc >= 6, 1'b0);
        cycle();
        if (last_acc) i++;
        cyc++;
      end
      check("bp_all_accepted", 32'(i), 32'd5);
    end
    idle(STAGES + 3);

    // Flush with two ops in flight and a new op offered in the flush cycle.
    drive(1'b1, 2'b10, 7'h00, 3'd4, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'b01, 7'h00, 3'd2, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'b10, 7'h20, 3'd5, 1'b0, 1'b1);
    cycle();
    idle(STAGES + 2);

    // Async reset with a full pipeline.
    repeat (3) begin
      drive(1'b1, 2'b10, 7'h20, 3'd0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 2'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("arst_cnt", 32'(illegal_cnt), 32'd0);
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Random traffic.
    repeat (400) begin
      logic [6:0] f7;
      bit         fl;
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      fl = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom), f7, 3'($urandom),
            fl ? 1'b0 : ($urandom_range(0, 2) != 0), fl);
      cycle();
    end
    idle(STAGES + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
